// File: rtl/rotary_pkg.sv
// Shared encodings for the rotary decoder: FSM states,
// quadrature step classification, direction and speed defaults.
package rotary_pkg;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_CW   = 2'd1,
    STEP_CCW  = 2'd2,
    STEP_BAD  = 2'd3
  } step_e;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  localparam int SPD_MIN_DEF = 1;
  localparam int SPD_MAX_DEF = 31;

  // Clockwise walk {a,b}: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] cw_next(
    input logic [1:0] ab
  );
    logic [1:0] nxt;
    unique case (ab)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  function automatic step_e quad_step(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    step_e s;
    unique case (1'b1)
      (prev == cur):             s = STEP_NONE;
      ((prev ^ cur) == 2'b11):   s = STEP_BAD;
      (cur == cw_next(prev)):    s = STEP_CW;
      default:                   s = STEP_CCW;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rotary_filter.sv
// One quadrature channel: 2-FF synchronizer followed by a stability
// filter that only follows the input after FILT_LEN disagreeing cycles.
module rotary_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic filt_out
);

  localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_out = filt_q;

endmodule

// File: rtl/rotary_decoder.sv
// Quadrature decoder: debounced channels, detent accumulation,
// one-cycle event pulses and a speed ramp for fast repeated turns.
module rotary_decoder
  import rotary_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int STEPS    = 4,
  parameter int FAST_GAP = 2000000,
  parameter int SPD_MIN  = SPD_MIN_DEF,
  parameter int SPD_MAX  = SPD_MAX_DEF,
  parameter int SPD_STEP = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rotary_a,
  input  logic       rotary_b,
  output logic       rotary_event,
  output logic       rotary_right,
  output logic [4:0] speed
);

  localparam logic [4:0]        PRIME_LEN = 5'(FILT_LEN + 2);
  localparam logic signed [4:0] ACC_POS   = 5'(STEPS);
  localparam logic signed [4:0] ACC_NEG   = 5'(-STEPS);
  localparam logic [23:0]       GAP_MAX   = 24'hFF_FFFF;
  localparam logic [23:0]       GAP_FAST  = 24'(FAST_GAP);

  logic filt_a, filt_b;

  rotary_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .clock    (clock),
    .reset    (reset),
    .raw_in   (rotary_a),
    .filt_out (filt_a)
  );

  rotary_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .clock    (clock),
    .reset    (reset),
    .raw_in   (rotary_b),
    .filt_out (filt_b)
  );

  state_e            state_q, state_d;
  logic [4:0]        prime_q, prime_d;
  logic [1:0]        prev_ab_q, prev_ab_d;
  logic signed [4:0] acc_q, acc_d;
  logic [23:0]       gap_q, gap_d;
  logic              evt_q, evt_d;
  logic              right_q, right_d;
  logic [4:0]        speed_q, speed_d;
  logic              seen_q, seen_d;

  logic [1:0]        ab;
  step_e             step;
  logic              fire;
  logic              dir;
  logic signed [4:0] acc_base;
  logic [5:0]        spd_sum;
  logic [4:0]        spd_fast;

  always_comb begin
    ab       = {filt_a, filt_b};
    step     = quad_step(prev_ab_q, ab);
    fire     = (state_q == RUN) &&
               ((acc_q == ACC_POS) || (acc_q == ACC_NEG));
    dir      = acc_q[4] ? DIR_CCW : DIR_CW;
    acc_base = fire ? '0 : acc_q;
    spd_sum  = {1'b0, speed_q} + 6'(SPD_STEP);
    spd_fast = (spd_sum > 6'(SPD_MAX)) ? 5'(SPD_MAX)
                                       : spd_sum[4:0];

    state_d   = state_q;
    prime_d   = prime_q;
    prev_ab_d = prev_ab_q;
    acc_d     = acc_q;
    evt_d     = 1'b0;
    right_d   = right_q;
    speed_d   = speed_q;
    seen_d    = seen_q;
    gap_d     = (gap_q == GAP_MAX) ? gap_q : gap_q + 24'd1;

    unique case (state_q)
      PRIME: begin
        // Wait until the filters have settled on the idle pins
        if (prime_q == PRIME_LEN) begin
          prev_ab_d = ab;
          state_d   = RUN;
        end else begin
          prime_d = prime_q + 5'd1;
        end
      end
      RUN: begin
        prev_ab_d = ab;
        unique case (step)
          STEP_NONE: acc_d = acc_base;
          STEP_CW:   acc_d = acc_base + 5'sd1;
          STEP_CCW:  acc_d = acc_base - 5'sd1;
          STEP_BAD:  acc_d = '0;
        endcase
      end
    endcase

    if (fire) begin
      evt_d   = 1'b1;
      right_d = dir;
      gap_d   = '0;
      seen_d  = 1'b1;
      // Ramp only on a quick repeat in the same direction
      if (seen_q && (gap_q < GAP_FAST) && (dir == right_q)) begin
        speed_d = spd_fast;
      end else begin
        speed_d = 5'(SPD_MIN);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= PRIME;
      prime_q   <= '0;
      prev_ab_q <= '0;
      acc_q     <= '0;
      gap_q     <= '0;
      evt_q     <= 1'b0;
      right_q   <= 1'b0;
      speed_q   <= 5'(SPD_MIN);
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prime_q   <= prime_d;
      prev_ab_q <= prev_ab_d;
      acc_q     <= acc_d;
      gap_q     <= gap_d;
      evt_q     <= evt_d;
      right_q   <= right_d;
      speed_q   <= speed_d;
      seen_q    <= seen_d;
    end
  end

  assign rotary_event = evt_q;
  assign rotary_right = right_q;
  assign speed        = speed_q;

endmodule
